hls_long_tail_mem_arb: RTL and testbench
========================================

HLS_LONG_TAIL_MEM_ARB -- requirements
Module: hls_long_tail_mem_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DEPTH, default 16, memory words.
REQ-003 SHALL have parameter DBITS, default 32, word width.
REQ-004 SHALL have parameter BANK, default 4, byte-write lanes per word.
REQ-005 SHALL have parameter ABITS, default $clog2(DEPTH), address width.
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-007 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port req_valid, input, NREQ, per-requester request valid.
REQ-009 SHALL have port req_ready, output, NREQ, per-requester grant (accept this cycle).
REQ-010 SHALL have port req_we, input, NREQ x BANK, lane write enables; 0 = read.
REQ-011 SHALL have port req_addr, input, NREQ x ABITS, word address.
REQ-012 SHALL have port req_wdata, input, NREQ x DBITS, write data.
REQ-013 SHALL have port rsp_valid, output, NREQ, response strobe.
REQ-014 SHALL have port rsp_rdata, output, NREQ x DBITS, read data (pre-write contents for writes).
REQ-015 SHALL have ports ce0/ce1 (output, 1), we0/we1 (output, BANK), address0/address1 (output, ABITS), d0/d1 (output, DBITS), q0/q1 (input, DBITS), which drive a dual-port byte-write memory with 1-cycle read latency.
REQ-016 SHALL have port conflict_cnt, output, 16, saturating count of deferred same-address grants.

Function
REQ-017 SHALL grant at most two requests per cycle: first winner on port 0, second winner on port 1.
REQ-018 SHALL pick winners round-robin starting at pointer rr_ptr, scanning indices rr_ptr, rr_ptr+1, ... modulo NREQ.
REQ-019 SHALL advance rr_ptr to (last granted index + 1) mod NREQ after any grant; it SHALL hold when nothing is granted.
REQ-020 SHALL assert req_ready[i] combinationally only when req_valid[i] and i is granted; a transfer occurs when valid and ready are both high.
REQ-021 SHALL drive ce/we/address/d of a port combinationally from its granted requester; with no grant, ce=0 and we=0.
REQ-022 SHALL deny the second winner when its address equals the first winner's and either request has a nonzero we; the denied requester remains first in scan order next cycle, and conflict_cnt SHALL increment (saturating at 0xFFFF).
REQ-023 SHALL assert rsp_valid[i] exactly one cycle after request i is accepted, with rsp_rdata[i] = q of the port that served it; rsp_valid SHALL be 0 otherwise.
REQ-024 SHALL register the per-port requester index and a valid bit for response routing; rsp_rdata of non-responding requesters SHALL hold their last value.
REQ-025 SHALL return a response for writes, carrying the word's contents before the write.
REQ-026 SHALL treat requesters that deassert req_valid without ready as withdrawn, with no side effect.
REQ-027 SHALL allow back-to-back acceptance from one requester when it is the only one valid (full throughput, up to one request per port per cycle across requesters).

Reset
REQ-028 SHALL, while rstn=0, force rr_ptr=0, response valid bits=0, rsp_valid=0, rsp_rdata=0, conflict_cnt=0, and req_ready/ce0/ce1=0.
REQ-029 SHALL discard any response in flight when reset asserts mid-operation; no rsp_valid follows deassertion.

Structure
REQ-030 SHALL place the response-routing struct (valid, requester index) and the conflict-counter width constant in package hls_long_tail_pkg.
REQ-031 SHALL implement winner selection in one sub-module hls_long_tail_rr_pick (request mask + pointer in, one-hot winner out), instantiated twice with the first winner masked out for the second instance.

Verification
REQ-032 SHALL test: all four requesters valid, reads at addr 0..3, rr_ptr=0 -> cycle 0 grants 0 (port 0) and 1 (port 1), cycle 1 grants 2 and 3, then rr_ptr=0.
REQ-033 SHALL test: requester 1 writes 0xAABBCCDD with we=4'b1111 at addr 5, then reads addr 5 -> read rsp_rdata = 0xAABBCCDD one cycle after acceptance.
REQ-034 SHALL test: requesters 0 and 2 both write addr 7 in the same cycle -> only 0 granted; 2 granted next cycle; conflict_cnt=1.
REQ-035 SHALL test: requesters 0 and 1 both read addr 7 in the same cycle -> both granted, no conflict, identical rsp_rdata.
REQ-036 SHALL test: partial write we=4'b0010 of 0x0000_5500 over 0x11223344 -> subsequent read = 0x11225544.
REQ-037 SHALL test: rstn pulsed low the cycle after acceptance -> no rsp_valid follows, and rr_ptr=0 at first grant after release.

Source files
------------

// File: rtl/hls_long_tail_pkg.sv
// Shared types for the long-tail memory arbiter.
// Response-routing record, counter width, one-hot decode helper.
package hls_long_tail_pkg;

  localparam int CNT_W = 16;
  localparam int IDX_W = 3;

  typedef struct packed {
    logic             v;
    logic [IDX_W-1:0] idx;
  } rsp_route_t;

  function automatic logic [IDX_W-1:0] oh2idx(
    input logic [7:0] oh
  );
    oh2idx = '0;
    for (int i = 0; i < 8; i++)
      if (oh[i]) oh2idx = IDX_W'(i);
  endfunction

endpackage

// File: rtl/hls_long_tail_rr_pick.sv
// Round-robin picker: first set bit of mask at or after ptr.
// Ports: mask (requests), ptr (scan start), win (one-hot winner).
module hls_long_tail_rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win
);

  always_comb begin
    logic found;
    int   idx;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && mask[PW'(idx)]) begin
        win[PW'(idx)] = 1'b1;
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hls_long_tail_mem_arb.sv
// Two-port round-robin arbiter in front of a dual-port byte-write RAM.
// Ports: req_* per requester, rsp_* per requester, ce/we/address/d/q
// per RAM port, conflict_cnt counts deferred same-address grants.
module hls_long_tail_mem_arb
  import hls_long_tail_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DEPTH = 16,
  parameter int DBITS = 32,
  parameter int BANK  = 4,
  parameter int ABITS = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*BANK-1:0]  req_we,
  input  logic [NREQ*ABITS-1:0] req_addr,
  input  logic [NREQ*DBITS-1:0] req_wdata,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [NREQ*DBITS-1:0] rsp_rdata,
  output logic                  ce0,
  output logic [BANK-1:0]       we0,
  output logic [ABITS-1:0]      address0,
  output logic [DBITS-1:0]      d0,
  input  logic [DBITS-1:0]      q0,
  output logic                  ce1,
  output logic [BANK-1:0]       we1,
  output logic [ABITS-1:0]      address1,
  output logic [DBITS-1:0]      d1,
  input  logic [DBITS-1:0]      q1,
  output logic [CNT_W-1:0]      conflict_cnt
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]         rr_ptr;
  logic [NREQ-1:0]       win0, win1, mask1;
  logic [IDX_W-1:0]      i0, i1;
  logic [ABITS-1:0]      a0, a1;
  logic [BANK-1:0]       w0e, w1e;
  logic [DBITS-1:0]      dd0, dd1;
  logic                  conflict, gnt0, gnt1;
  rsp_route_t            rt0, rt1;
  logic [NREQ*DBITS-1:0] hold;

  assign mask1 = req_valid & ~win0;

  hls_long_tail_rr_pick #(.N(NREQ), .PW(PW)) u_pick0 (
    .mask (req_valid),
    .ptr  (rr_ptr),
    .win  (win0)
  );

  hls_long_tail_rr_pick #(.N(NREQ), .PW(PW)) u_pick1 (
    .mask (mask1),
    .ptr  (rr_ptr),
    .win  (win1)
  );

  assign i0 = oh2idx(8'(win0));
  assign i1 = oh2idx(8'(win1));

  always_comb begin
    a0  = '0;
    a1  = '0;
    w0e = '0;
    w1e = '0;
    dd0 = '0;
    dd1 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win0[i]) begin
        a0  = req_addr[i*ABITS +: ABITS];
        w0e = req_we[i*BANK +: BANK];
        dd0 = req_wdata[i*DBITS +: DBITS];
      end
      if (win1[i]) begin
        a1  = req_addr[i*ABITS +: ABITS];
        w1e = req_we[i*BANK +: BANK];
        dd1 = req_wdata[i*DBITS +: DBITS];
      end
    end
  end

  // Same word touched twice with a write involved: defer port 1.
  assign conflict = rstn && (|win0) && (|win1)
                 && (a0 == a1) && ((|w0e) || (|w1e));
  assign gnt0 = rstn && (|win0);
  assign gnt1 = rstn && (|win1) && !conflict;

  assign req_ready = !rstn    ? '0 :
                     conflict ? win0 : (win0 | win1);

  assign ce0      = gnt0;
  assign we0      = gnt0 ? w0e : '0;
  assign address0 = a0;
  assign d0       = dd0;
  assign ce1      = gnt1;
  assign we1      = gnt1 ? w1e : '0;
  assign address1 = a1;
  assign d1       = dd1;

  // Non-responders present their last delivered word.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = hold;
    for (int i = 0; i < NREQ; i++) begin
      if (rt0.v && rt0.idx == IDX_W'(i)) begin
        rsp_valid[i]                 = 1'b1;
        rsp_rdata[i*DBITS +: DBITS] = q0;
      end
      if (rt1.v && rt1.idx == IDX_W'(i)) begin
        rsp_valid[i]                 = 1'b1;
        rsp_rdata[i*DBITS +: DBITS] = q1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr       <= '0;
      rt0          <= '0;
      rt1          <= '0;
      conflict_cnt <= '0;
      hold         <= '0;
    end else begin
      rt0  <= '{v: gnt0, idx: i0};
      rt1  <= '{v: gnt1, idx: i1};
      hold <= rsp_rdata;
      // Deferred requester heads the scan next cycle.
      if (conflict)
        rr_ptr <= PW'(i1);
      else if (gnt1)
        rr_ptr <= PW'((int'(i1) + 1) % NREQ);
      else if (gnt0)
        rr_ptr <= PW'((int'(i0) + 1) % NREQ);
      if (conflict && conflict_cnt != '1)
        conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hls_long_tail_mem_arb.sv
// Bench for hls_long_tail_mem_arb: directed cases then random traffic.
// Reference model: round-robin scan over a word array.
module tb_hls_long_tail_mem_arb;

  localparam int N = 4;
  localparam int A = 4;
  localparam int D = 32;
  localparam int B = 4;

  logic         clk = 1'b0;
  logic         rstn;
  logic [N-1:0] req_valid, req_ready, rsp_valid;
  logic [N*B-1:0] req_we;
  logic [N*A-1:0] req_addr;
  logic [N*D-1:0] req_wdata, rsp_rdata;
  logic         ce0, ce1;
  logic [B-1:0] we0, we1;
  logic [A-1:0] address0, address1;
  logic [D-1:0] d0, d1;
  logic [D-1:0] q0 = '0, q1 = '0;
  logic [15:0]  conflict_cnt;

  always #5 clk = ~clk;

  hls_long_tail_mem_arb dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ce0(ce0), .we0(we0), .address0(address0),
    .d0(d0), .q0(q0),
    .ce1(ce1), .we1(we1), .address1(address1),
    .d1(d1), .q1(q1),
    .conflict_cnt(conflict_cnt)
  );

  logic [D-1:0] mem [16] = '{default: '0};

  always @(posedge clk) begin
    if (ce0) q0 <= mem[address0];
    if (ce1) q1 <= mem[address1];
    for (int b = 0; b < B; b++) begin
      if (we0[b]) mem[address0][b*8 +: 8] <= d0[b*8 +: 8];
      if (we1[b]) mem[address1][b*8 +: 8] <= d1[b*8 +: 8];
    end
  end

  int checks = 0;
  int errs   = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  int           ptr;
  int           ccnt;
  logic [D-1:0] rmem [16] = '{default: '0};
  logic [D-1:0] last [N];
  logic [D-1:0] nrd  [N];
  logic [N-1:0] nrv;
  logic [N-1:0] gr;

  function automatic int ad(int i);
    return int'(req_addr[i*A +: A]);
  endfunction

  function automatic logic [B-1:0] wev(int i);
    return req_we[i*B +: B];
  endfunction

  task automatic pre();
    int           w0, w1, i;
    logic         conf;
    logic [N-1:0] er;
    logic [B-1:0] m;
    #1;
    w0 = -1;
    w1 = -1;
    for (int k = 0; k < N; k++) begin
      i = (ptr + k) % N;
      if (req_valid[i]) begin
        if (w0 < 0) w0 = i;
        else if (w1 < 0) w1 = i;
      end
    end
    conf = (w1 >= 0) && ad(w0) == ad(w1)
        && (wev(w0) != 0 || wev(w1) != 0);
    er = '0;
    if (w0 >= 0) er[w0] = 1'b1;
    if (w1 >= 0 && !conf) er[w1] = 1'b1;
    gr = req_ready;
    chk("ready", 32'(req_ready), 32'(er));
    chk("ce0", 32'(ce0), 32'(w0 >= 0));
    chk("ce1", 32'(ce1), 32'(w1 >= 0 && !conf));
    nrv = er;
    for (int j = 0; j < N; j++)
      if (er[j]) nrd[j] = rmem[ad(j)];
    for (int j = 0; j < N; j++)
      if (er[j]) begin
        m = wev(j);
        for (int b = 0; b < B; b++)
          if (m[b])
            rmem[ad(j)][b*8 +: 8] = req_wdata[j*D + b*8 +: 8];
      end
    if (conf) begin
      ptr = w1;
      if (ccnt < 65535) ccnt++;
    end else if (w1 >= 0) ptr = (w1 + 1) % N;
    else if (w0 >= 0) ptr = (w0 + 1) % N;
  endtask

  task automatic post();
    logic [D-1:0] e;
    chk("rsp_valid", 32'(rsp_valid), 32'(nrv));
    for (int i = 0; i < N; i++) begin
      e = nrv[i] ? nrd[i] : last[i];
      chk("rsp_rdata", rsp_rdata[i*D +: D], e);
      last[i] = e;
    end
    chk("conflict_cnt", 32'(conflict_cnt), 32'(ccnt));
  endtask

  task automatic cyc();
    pre();
    @(posedge clk);
    #1;
    post();
  endtask

  task automatic model_reset();
    ptr  = 0;
    ccnt = 0;
    nrv  = '0;
    for (int i = 0; i < N; i++) last[i] = '0;
  endtask

  task automatic clr();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic rq(int i, logic [B-1:0] we, int a,
                    logic [D-1:0] wd);
    req_valid[i]        = 1'b1;
    req_we[i*B +: B]    = we;
    req_addr[i*A +: A]  = A'(a);
    req_wdata[i*D +: D] = wd;
  endtask

  task automatic park();
    clr();
    rq(3, '0, 0, '0);
    cyc();
  endtask

  initial begin
    clr();
    rstn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) rq(i, 4'hf, i, 32'h1);
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_ce", 32'({ce0, ce1}), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rdata", rsp_rdata[31:0], 32'h0);
    chk("rst_cnt", 32'(conflict_cnt), 32'h0);
    clr();
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Four readers, two grants per cycle.
    for (int i = 0; i < N; i++) rq(i, '0, i, '0);
    cyc();
    chk("t32_c0", 32'(gr), 32'h3);
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    cyc();
    chk("t32_c1", 32'(gr), 32'hc);
    for (int i = 0; i < N; i++) rq(i, '0, i, '0);
    cyc();
    chk("t32_wrap", 32'(gr), 32'h3);

    // Full write then read back.
    clr();
    rq(1, 4'hf, 5, 32'hAABBCCDD);
    cyc();
    rq(1, 4'h0, 5, '0);
    cyc();
    chk("t33_v", 32'(rsp_valid[1]), 32'h1);
    chk("t33_d", rsp_rdata[1*D +: D], 32'hAABBCCDD);

    // Same-address writes collide.
    park();
    clr();
    rq(0, 4'hf, 7, 32'h01010101);
    rq(2, 4'hf, 7, 32'h02020202);
    cyc();
    chk("t34_c0", 32'(gr), 32'h1);
    req_valid[0] = 1'b0;
    cyc();
    chk("t34_c1", 32'(gr), 32'h4);
    chk("t34_cnt", 32'(conflict_cnt), 32'h1);

    // Same-address reads both proceed.
    park();
    clr();
    rq(0, '0, 7, '0);
    rq(1, '0, 7, '0);
    cyc();
    chk("t35_g", 32'(gr), 32'h3);
    chk("t35_d0", rsp_rdata[0 +: D], 32'h02020202);
    chk("t35_d1", rsp_rdata[D +: D], 32'h02020202);
    chk("t35_cnt", 32'(conflict_cnt), 32'h1);

    // Byte-lane merge.
    clr();
    rq(0, 4'hf, 9, 32'h11223344);
    cyc();
    rq(0, 4'b0010, 9, 32'h00005500);
    cyc();
    rq(0, 4'h0, 9, '0);
    cyc();
    chk("t36_d", rsp_rdata[0 +: D], 32'h11225544);

    // Reset with a response in flight.
    clr();
    rq(2, '0, 1, '0);
    pre();
    @(posedge clk);
    #1;
    rstn = 1'b0;
    model_reset();
    #1;
    chk("t37_flush", 32'(rsp_valid), 32'h0);
    clr();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    #1;
    chk("t37_quiet", 32'(rsp_valid), 32'h0);
    @(posedge clk);
    #1;
    chk("t37_quiet2", 32'(rsp_valid), 32'h0);
    for (int i = 0; i < N; i++) rq(i, '0, i + 8, '0);
    cyc();
    chk("t37_ptr0", 32'(gr), 32'h3);

    // Random traffic on a few hot addresses.
    repeat (400) begin
      clr();
      for (int i = 0; i < N; i++)
        if ($urandom_range(2) != 0)
          rq(i,
             ($urandom_range(1) == 0) ? 4'h0 : B'($urandom),
             int'($urandom_range(3)), $urandom);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
    $finish;
  end

endmodule
